p405s_icu_linefill_seq: RTL and testbench
=========================================

Name: p405s_icu_linefill_seq

Overview:
Instruction-cache line-fill sequencer directly upstream of the ICU 32-bit datapath register (p405s_icu_dp_regICU_vb0). It issues one line-fill request and collects PLB read beats, which arrive target-word-first with wrap, into a line buffer. It drives the register's D/E1 pair: the critical word is forwarded on the cycle it arrives, and later sequential words are forwarded from the buffer on request.

Parameters:
LINE_WORDS, 8, words per cache line; power of 2, minimum 2.
IDX_W, 3, word-index width; equals log2(LINE_WORDS).

Ports:
CB  in  1  clock; all state updates on the rising edge.
RESETN  in  1  asynchronous active-low reset.
REQ_VLD  in  1  miss request from ICU control.
REQ_ADDR  in  [0:29]  word address of the missed instruction.
REQ_ACK  out  1  request accepted; single-cycle pulse.
PLB_RDDACK  in  1  read data beat valid.
PLB_RDDBUS  in  [0:31]  read data beat.
PLB_RDWDADDR  in  [0:IDX_W-1]  word index of the beat within the line.
RD_REQ  in  1  request to forward a buffered word.
RD_IDX  in  [0:IDX_W-1]  word index to forward.
RD_ACK  out  1  RD_REQ serviced this cycle.
FWD_D  out  [0:31]  to register D.
FWD_E1  out  1  to register E1; register captures FWD_D.
WORD_VLD  out  [0:LINE_WORDS-1]  per-word valid.
FILL_BUSY  out  1  state not IDLE.
FILL_DONE  out  1  one-cycle pulse when the line is complete.
FILL_ERR  out  1  sticky flag: duplicate beat or protocol error; cleared by the next REQ_ACK.

Behaviour:
- Reset (asynchronous, RESETN=0):
  - state=IDLE; all outputs 0; WORD_VLD=0; beat count=0.
  - Buffer data is not reset.
- States:
  - IDLE: on REQ_VLD, pulse REQ_ACK. Latch line address REQ_ADDR[0:29-IDX_W] and target index REQ_ADDR[30-IDX_W:29]. Clear WORD_VLD and FILL_ERR; go to FILL. REQ_VLD outside IDLE is ignored (no ACK).
  - FILL: each PLB_RDDACK writes PLB_RDDBUS to buffer[PLB_RDWDADDR], sets its WORD_VLD bit and increments the beat count. When the count reaches LINE_WORDS, go to DONE.
  - DONE: pulse FILL_DONE for one cycle, then go to IDLE. WORD_VLD and the buffer remain valid until the next REQ_ACK.
- Critical-word forwarding:
  - In FILL, a beat with PLB_RDWDADDR == target index drives FWD_D=PLB_RDDBUS and FWD_E1=1 combinationally in the same cycle, giving zero-cycle bypass.
  - The register output L2 therefore shows the word one CB edge after the beat.
- Buffered forwarding: RD_REQ with WORD_VLD[RD_IDX]=1 and no critical beat in that cycle gives FWD_D=buffer[RD_IDX], FWD_E1=1, RD_ACK=1, all combinational.
- Priority: a critical-beat forward beats RD_REQ. A losing RD_REQ gets RD_ACK=0 and must be held by the requester.
- RD_REQ on an invalid word: RD_ACK=0, FWD_E1=0, no error.
- Same-cycle beat and RD_REQ of the same (non-critical) index: the word is not yet valid, so RD_ACK=0. It is forwarded the next cycle if the request is held.
- Error cases (the count still increments, DONE is still reached, then FILL_ERR is set):
  - Duplicate beat (WORD_VLD already set): data is overwritten.
  - First beat not at the target index: the word is stored, but the critical forward occurs only when the target beat arrives.
- Ignored inputs: PLB_RDDACK in IDLE or DONE is ignored and sets FILL_ERR.
- Reset mid-fill: fill is abandoned, WORD_VLD is cleared, no FILL_DONE.
- When no forward occurs, FWD_D is 0 (not X).

Optional Feature:
ICU_FILL_PARITY_EN.
- Defined:
  - Adds input PLB_RDDPAR [0:3], even parity per byte, and stores 4 parity bits per word.
  - A beat with bad parity leaves WORD_VLD clear and suppresses that beat's forwarding.
  - Adds output PAR_ERR: a one-cycle pulse on the offending beat. The line still completes.
- Undefined: no parity ports or storage; behaviour is as above.

Decomposition:
- Shared package p405s_icu_pkg holds:
  - the state encoding constants (IDLE=2'b00, FILL=2'b01, DONE=2'b10);
  - the LINE_WORDS and IDX_W defaults;
  - the byte-parity function.
- One sub-module, p405s_icu_linefill_buf: LINE_WORDS x 32 storage with a write port, a combinational read port and the valid vector. The FSM and forwarding mux stay in the top level.

Test Plan:
1. Reset release, then REQ_VLD with REQ_ADDR=0x00000105 (target 5) -> REQ_ACK pulse. Beats 5,6,7,0..4 with data 0xA0000000+idx -> FWD_E1=1 and FWD_D=0xA0000005 in the first beat cycle only. FILL_DONE one cycle after the 8th beat; WORD_VLD=0xFF.
2. During that fill, RD_REQ idx 6 in the cycle after beat 6 -> RD_ACK=1, FWD_D=0xA0000006. RD_REQ idx 3 before beat 3 -> RD_ACK=0 until beat 3 lands.
3. RD_REQ idx 2 (valid) in the same cycle as the critical beat -> critical word forwarded, RD_ACK=0; RD_ACK=1 the next cycle.
4. Beat index 4 delivered twice in one fill -> FILL_ERR=1 after DONE; buffer[4] holds the second value. The next REQ_ACK clears FILL_ERR.
5. RESETN asserted after 3 beats -> all outputs and WORD_VLD are 0 asynchronously. A new request then completes normally.
6. With ICU_FILL_PARITY_EN: corrupt parity on beat 2 -> PAR_ERR pulse, WORD_VLD[2]=0, no forward if beat 2 is the critical word.

Source files
------------

// File: rtl/p405s_icu_pkg.sv
// Shared definitions for the ICU line-fill path.
//   - fill sequencer state encoding
//   - default line geometry (words per line, word-index width)
//   - byte-parity helper used by the optional beat parity check
package p405s_icu_pkg;

    localparam int LINE_WORDS_DEF = 8;
    localparam int IDX_W_DEF      = 3;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        FILL = 2'b01,
        DONE = 2'b10
    } fill_state_e;

    // Even parity per byte: each bit makes its byte plus itself even.
    // Byte 0 is bits [0:7] (most significant byte).
    function automatic logic [0:3] byte_par(input logic [0:31] d);
        logic [0:3] p;
        for (int k = 0; k < 4; k++) p[k] = ^d[8*k +: 8];
        return p;
    endfunction

endpackage

// File: rtl/p405s_icu_linefill_buf.sv
// Line buffer for the ICU line-fill sequencer.
//   gclk/grst_n : clock, async active-low reset (valid bits only)
//   clr         : clear every valid bit (new fill accepted)
//   we/widx/wdata, set_vld : write port; set_vld marks the word valid
//   ridx/rdata  : combinational read port
//   vld         : per-word valid vector, bit i = word i
// With ICU_FILL_PARITY_EN the buffer also keeps 4 parity bits per word
// (wpar in, rpar out). Data and parity storage are not reset.
module p405s_icu_linefill_buf
    import p405s_icu_pkg::*;
#(
    parameter int LINE_WORDS = LINE_WORDS_DEF,
    parameter int IDX_W      = IDX_W_DEF
) (
    input  logic                  gclk,
    input  logic                  grst_n,
    input  logic                  clr,
    input  logic                  we,
    input  logic                  set_vld,
    input  logic [0:IDX_W-1]      widx,
    input  logic [0:31]           wdata,
`ifdef ICU_FILL_PARITY_EN
    input  logic [0:3]            wpar,
    output logic [0:3]            rpar,
`endif
    input  logic [0:IDX_W-1]      ridx,
    output logic [0:31]           rdata,
    output logic [0:LINE_WORDS-1] vld
);

    logic [0:31] mem [LINE_WORDS];

    always_ff @(posedge gclk) begin
        if (we) mem[widx] <= wdata;
    end

    assign rdata = mem[ridx];

`ifdef ICU_FILL_PARITY_EN
    logic [0:3] par_mem [LINE_WORDS];

    always_ff @(posedge gclk) begin
        if (we) par_mem[widx] <= wpar;
    end

    assign rpar = par_mem[ridx];
`endif

    // clr and we never coincide: clear happens on accept in IDLE,
    // writes only happen in FILL.
    always_ff @(posedge gclk or negedge grst_n) begin
        if (!grst_n)             vld <= '0;
        else if (clr)            vld <= '0;
        else if (we && set_vld)  vld[widx] <= 1'b1;
    end

endmodule

// File: rtl/p405s_icu_linefill_seq.sv
// ICU instruction-cache line-fill sequencer.
// Accepts one miss request, collects wrapped PLB read beats into a line
// buffer and drives the D/E1 pair of the downstream ICU datapath register.
//   CB, RESETN       : clock, async active-low reset
//   REQ_VLD/REQ_ADDR : miss request (word address); REQ_ACK one-cycle accept
//   PLB_RDDACK/PLB_RDDBUS/PLB_RDWDADDR : read beat and its word index
//   RD_REQ/RD_IDX    : forward a buffered word; RD_ACK when serviced
//   FWD_D/FWD_E1     : register data / capture enable
//   WORD_VLD         : per-word valid; FILL_BUSY state != IDLE
//   FILL_DONE        : one-cycle pulse on line complete
//   FILL_ERR         : sticky protocol error, cleared on next accept
// Optional build macro ICU_FILL_PARITY_EN adds PLB_RDDPAR (even byte
// parity) and PAR_ERR (pulse on a beat with bad parity).
module p405s_icu_linefill_seq
    import p405s_icu_pkg::*;
#(
    parameter int LINE_WORDS = LINE_WORDS_DEF,
    parameter int IDX_W      = IDX_W_DEF
) (
    input  logic                  CB,
    input  logic                  RESETN,
    input  logic                  REQ_VLD,
    input  logic [0:29]           REQ_ADDR,
    output logic                  REQ_ACK,
    input  logic                  PLB_RDDACK,
    input  logic [0:31]           PLB_RDDBUS,
    input  logic [0:IDX_W-1]      PLB_RDWDADDR,
`ifdef ICU_FILL_PARITY_EN
    input  logic [0:3]            PLB_RDDPAR,
    output logic                  PAR_ERR,
`endif
    input  logic                  RD_REQ,
    input  logic [0:IDX_W-1]      RD_IDX,
    output logic                  RD_ACK,
    output logic [0:31]           FWD_D,
    output logic                  FWD_E1,
    output logic [0:LINE_WORDS-1] WORD_VLD,
    output logic                  FILL_BUSY,
    output logic                  FILL_DONE,
    output logic                  FILL_ERR
);

    localparam logic [IDX_W:0] LAST_BEAT = (IDX_W+1)'(LINE_WORDS - 1);

    fill_state_e          state;
    logic [0:29-IDX_W]    line_addr;
    logic [0:IDX_W-1]     tgt_idx;
    logic [IDX_W:0]       beat_cnt;
    logic                 err_pend;
    logic [0:31]          rd_data;
    logic                 accept, beat, beat_ok, beat_err, crit, rd_par_ok;

    // Line address is kept for the fill's lifetime; nothing here consumes it.
    logic unused_line_addr;
    assign unused_line_addr = ^line_addr;

    assign accept = (state == IDLE) && REQ_VLD;
    assign beat   = (state == FILL) && PLB_RDDACK;

`ifdef ICU_FILL_PARITY_EN
    logic [0:3] rd_par;
    assign beat_ok   = beat && (byte_par(PLB_RDDBUS) == PLB_RDDPAR);
    assign PAR_ERR   = beat && !beat_ok;
    assign rd_par_ok = (byte_par(rd_data) == rd_par);
`else
    assign beat_ok   = beat;
    assign rd_par_ok = 1'b1;
`endif

    // Duplicate beat, or a first beat that is not the target word.
    assign beat_err = beat && (WORD_VLD[PLB_RDWDADDR] ||
                               (beat_cnt == '0 && PLB_RDWDADDR != tgt_idx));

    // Critical word bypasses the buffer; it outranks any buffered read.
    // A read of a word landing this cycle sees the old (clear) valid bit.
    assign crit      = beat_ok && (PLB_RDWDADDR == tgt_idx);
    assign RD_ACK    = RD_REQ && WORD_VLD[RD_IDX] && rd_par_ok && !crit;
    assign FWD_E1    = crit || RD_ACK;
    assign FWD_D     = crit ? PLB_RDDBUS : (RD_ACK ? rd_data : '0);
    assign FILL_BUSY = (state != IDLE);
    assign FILL_DONE = (state == DONE);

    p405s_icu_linefill_buf #(
        .LINE_WORDS (LINE_WORDS),
        .IDX_W      (IDX_W)
    ) u_buf (
        .gclk    (CB),
        .grst_n  (RESETN),
        .clr     (accept),
        .we      (beat),
        .set_vld (beat_ok),
        .widx    (PLB_RDWDADDR),
        .wdata   (PLB_RDDBUS),
`ifdef ICU_FILL_PARITY_EN
        .wpar    (PLB_RDDPAR),
        .rpar    (rd_par),
`endif
        .ridx    (RD_IDX),
        .rdata   (rd_data),
        .vld     (WORD_VLD)
    );

    always_ff @(posedge CB or negedge RESETN) begin
        if (!RESETN) begin
            state     <= IDLE;
            REQ_ACK   <= 1'b0;
            FILL_ERR  <= 1'b0;
            err_pend  <= 1'b0;
            beat_cnt  <= '0;
            line_addr <= '0;
            tgt_idx   <= '0;
        end else begin
            REQ_ACK <= 1'b0;
            case (state)
                IDLE: begin
                    // A stray beat in IDLE still flags, even alongside a request.
                    if (PLB_RDDACK) FILL_ERR <= 1'b1;
                    if (REQ_VLD) begin
                        REQ_ACK   <= 1'b1;
                        line_addr <= REQ_ADDR[0:29-IDX_W];
                        tgt_idx   <= REQ_ADDR[30-IDX_W:29];
                        FILL_ERR  <= PLB_RDDACK;
                        err_pend  <= 1'b0;
                        beat_cnt  <= '0;
                        state     <= FILL;
                    end
                end
                FILL: begin
                    if (PLB_RDDACK) begin
                        beat_cnt <= beat_cnt + 1'b1;
                        if (beat_err) err_pend <= 1'b1;
                        // Errors are only reported once the line completes.
                        if (beat_cnt == LAST_BEAT) begin
                            state    <= DONE;
                            FILL_ERR <= err_pend || beat_err;
                        end
                    end
                end
                DONE: begin
                    if (PLB_RDDACK) FILL_ERR <= 1'b1;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_p405s_icu_linefill_seq.sv
// Self-checking bench for p405s_icu_linefill_seq: forwards are scored
// through a queue filled as stimulus is driven and drained on FWD_E1.
module tb_p405s_icu_linefill_seq;

    logic        CB = 1'b0;
    logic        RESETN = 1'b0;
    logic        REQ_VLD = 1'b0;
    logic [0:29] REQ_ADDR = '0;
    logic        REQ_ACK;
    logic        PLB_RDDACK = 1'b0;
    logic [0:31] PLB_RDDBUS = '0;
    logic [0:2]  PLB_RDWDADDR = '0;
    logic        RD_REQ = 1'b0;
    logic [0:2]  RD_IDX = '0;
    logic        RD_ACK;
    logic [0:31] FWD_D;
    logic        FWD_E1;
    logic [0:7]  WORD_VLD;
    logic        FILL_BUSY, FILL_DONE, FILL_ERR;
`ifdef ICU_FILL_PARITY_EN
    logic [0:3]  PLB_RDDPAR = '0;
    logic        PAR_ERR;
`endif

    p405s_icu_linefill_seq dut (
        .CB(CB), .RESETN(RESETN), .REQ_VLD(REQ_VLD), .REQ_ADDR(REQ_ADDR),
        .REQ_ACK(REQ_ACK), .PLB_RDDACK(PLB_RDDACK), .PLB_RDDBUS(PLB_RDDBUS),
        .PLB_RDWDADDR(PLB_RDWDADDR),
`ifdef ICU_FILL_PARITY_EN
        .PLB_RDDPAR(PLB_RDDPAR), .PAR_ERR(PAR_ERR),
`endif
        .RD_REQ(RD_REQ), .RD_IDX(RD_IDX), .RD_ACK(RD_ACK), .FWD_D(FWD_D),
        .FWD_E1(FWD_E1), .WORD_VLD(WORD_VLD), .FILL_BUSY(FILL_BUSY),
        .FILL_DONE(FILL_DONE), .FILL_ERR(FILL_ERR)
    );

    always #5 CB = ~CB;

    int          n_vec = 0;
    int          n_err = 0;
    logic [31:0] fwd_q[$];
    logic [31:0] m_mem [8];
    logic [0:7]  m_vld = '0;
    int          m_tgt = 0;
    logic        m_fill = 1'b0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h", tag, act, exp);
        end
    endtask

`ifdef ICU_FILL_PARITY_EN
    function automatic logic [0:3] tb_par(input logic [31:0] d);
        return {^d[31:24], ^d[23:16], ^d[15:8], ^d[7:0]};
    endfunction
`endif

    // Forward monitor, sampled on the falling edge.
    always @(negedge CB) begin
        if (FWD_E1) begin
            if (fwd_q.size() == 0) chk("fwd_unexp", FWD_E1, 0);
            else                   chk("fwd_d", FWD_D, fwd_q.pop_front());
        end else begin
            chk("fwd_d_zero", FWD_D, 0);
            if (fwd_q.size() != 0) begin
                chk("fwd_missing", FWD_E1, 1);
                void'(fwd_q.pop_front());
            end
        end
    end

    // One cycle of stimulus, called at posedge+1; returns at next posedge+1.
    task automatic cyc(input logic bv, input int bi, input logic [31:0] bd,
                       input logic rv, input int ri, input logic bp = 1'b0);
        logic crit, ack;
        PLB_RDDACK   = bv;
        PLB_RDWDADDR = bi[2:0];
        PLB_RDDBUS   = bd;
        RD_REQ       = rv;
        RD_IDX       = ri[2:0];
`ifdef ICU_FILL_PARITY_EN
        PLB_RDDPAR   = tb_par(bd) ^ {bp, 3'b000};
`endif
        crit = bv && m_fill && !bp && (bi == m_tgt);
        ack  = rv && m_vld[ri] && !crit;
        if (crit)     fwd_q.push_back(bd);
        else if (ack) fwd_q.push_back(m_mem[ri]);
        #1;
        chk("rd_ack", RD_ACK, ack);
        chk("no_done", FILL_DONE, 0);
`ifdef ICU_FILL_PARITY_EN
        chk("par_err", PAR_ERR, bv && m_fill && bp);
`endif
        @(posedge CB); #1;
        if (bv && m_fill) begin
            m_mem[bi] = bd;
            if (!bp) m_vld[bi] = 1'b1;
        end
        PLB_RDDACK = 1'b0;
        RD_REQ     = 1'b0;
    endtask

    task automatic req(input logic [0:29] addr);
        REQ_VLD  = 1'b1;
        REQ_ADDR = addr;
        @(posedge CB); #1;
        REQ_VLD = 1'b0;
        chk("req_ack", REQ_ACK, 1);
        chk("busy", FILL_BUSY, 1);
        chk("vld_clr", WORD_VLD, 0);
        chk("err_clr", FILL_ERR, 0);
        m_tgt  = int'(addr[27:29]);
        m_vld  = '0;
        m_fill = 1'b1;
    endtask

    task automatic wait_done(input logic [7:0] exp_vld, input logic exp_err);
        int n;
        n = 0;
        while (!FILL_DONE && n < 4) begin
            @(posedge CB); #1;
            n++;
        end
        chk("fill_done", FILL_DONE, 1);
        chk("word_vld", WORD_VLD, exp_vld);
        chk("fill_err", FILL_ERR, exp_err);
        m_fill = 1'b0;
        @(posedge CB); #1;
        chk("done_pulse", FILL_DONE, 0);
        chk("busy_idle", FILL_BUSY, 0);
    endtask

    int ord1 [8] = '{5, 6, 7, 0, 1, 2, 3, 4};
    int ord3 [8] = '{2, 3, 4, 5, 6, 7, 0, 1};
    int ord4 [8] = '{0, 1, 2, 3, 4, 4, 5, 6};
    int ord5 [8] = '{7, 0, 1, 2, 3, 4, 5, 6};

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int b;
        repeat (2) @(posedge CB);
        #1;
        chk("rst_ack", REQ_ACK, 0);
        chk("rst_busy", FILL_BUSY, 0);
        chk("rst_done", FILL_DONE, 0);
        chk("rst_err", FILL_ERR, 0);
        chk("rst_vld", WORD_VLD, 0);
        chk("rst_e1", FWD_E1, 0);
        #2 RESETN = 1'b1;
        @(posedge CB); #1;

        // Test 1/2: target 5, wrap order; buffered reads of 6 and of 3.
        req(30'h105);
        for (int i = 0; i < 8; i++) begin
            b = ord1[i];
            cyc(1'b1, b, 32'hA000_0000 + b, i >= 2, (i == 2) ? 6 : 3);
            if (i == 0) chk("ack_pulse", REQ_ACK, 0);
        end
        wait_done(8'hFF, 1'b0);

        // Stray beat in IDLE flags an error.
        cyc(1'b1, 3, 32'hDEAD_BEEF, 1'b0, 0);
        chk("stray_err", FILL_ERR, 1);

        // Test 3: first beat off-target; read of word 2 loses to critical beat.
        req(30'h203);
        for (int i = 0; i < 8; i++) begin
            b = ord3[i];
            cyc(1'b1, b, 32'hB000_0000 + b, i == 1 || i == 2, 2);
        end
        wait_done(8'hFF, 1'b1);

        // Test 4: word 4 delivered twice, word 7 never.
        req(30'h300);
        for (int i = 0; i < 8; i++) begin
            b = ord4[i];
            cyc(1'b1, b, 32'hC000_0000 + b + ((i == 5) ? 32'h40 : 32'h0), 1'b0, 0);
        end
        wait_done(8'hFE, 1'b1);
        cyc(1'b0, 0, 32'h0, 1'b1, 4);
        chk("err_sticky", FILL_ERR, 1);

        // Test 5: reset after 3 beats, then a clean fill.
        req(30'h007);
        for (int i = 0; i < 3; i++) begin
            b = ord5[i];
            cyc(1'b1, b, 32'hD000_0000 + b, 1'b0, 0);
        end
        RD_REQ = 1'b1;
        RD_IDX = 3'd0;
        #1 RESETN = 1'b0;
        #1;
        chk("arst_ack", REQ_ACK, 0);
        chk("arst_rdack", RD_ACK, 0);
        chk("arst_e1", FWD_E1, 0);
        chk("arst_d", FWD_D, 0);
        chk("arst_vld", WORD_VLD, 0);
        chk("arst_busy", FILL_BUSY, 0);
        chk("arst_done", FILL_DONE, 0);
        chk("arst_err", FILL_ERR, 0);
        RD_REQ = 1'b0;
        m_fill = 1'b0;
        m_vld  = '0;
        repeat (2) @(posedge CB);
        #3 RESETN = 1'b1;
        @(posedge CB); #1;
        req(30'h017);
        for (int i = 0; i < 8; i++) begin
            b = ord5[i];
            cyc(1'b1, b, 32'hE000_0000 + b, 1'b0, 0);
        end
        wait_done(8'hFF, 1'b0);

`ifdef ICU_FILL_PARITY_EN
        // Test 6: bad parity on the critical beat 2.
        req(30'h402);
        for (int i = 0; i < 8; i++) begin
            b = (2 + i) % 8;
            cyc(1'b1, b, 32'hF000_0000 + b, 1'b0, 0, i == 0);
        end
        wait_done(8'hDF, 1'b0);
`endif

        @(posedge CB); #1;
        chk("q_empty", fwd_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
